// File: rtl/posted_write_buffer_if.sv
// Signal bundle between the data cache memory port, the posted write buffer and memory.
// slave is the buffer's view (it serves the cache and drives memory); master is the environment's view.
interface posted_write_buffer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  up_req_i;
   logic [ADDR_WIDTH-1:0] up_addr_i;
   logic                  up_we_i;
   logic [BE_WIDTH-1:0]   up_be_i;
   logic [DATA_WIDTH-1:0] up_wdata_i;
   logic                  up_gnt_o;
   logic                  up_rvalid_o;
   logic [DATA_WIDTH-1:0] up_rdata_o;
   logic                  up_error_o;

   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_we_o;
   logic [BE_WIDTH-1:0]   mem_be_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  mem_error_i;

   modport slave (
      input  up_req_i, up_addr_i, up_we_i, up_be_i, up_wdata_i,
      output up_gnt_o, up_rvalid_o, up_rdata_o, up_error_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_error_i
   );

   modport master (
      output up_req_i, up_addr_i, up_we_i, up_be_i, up_wdata_i,
      input  up_gnt_o, up_rvalid_o, up_rdata_o, up_error_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_error_i
   );
endinterface

// File: rtl/posted_write_buffer.sv
// Posted write buffer: cache write-throughs are acknowledged after one cycle and drained to
// memory in order; reads reach memory only once the FIFO is empty, so they never pass a write.
module posted_write_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   posted_write_buffer_if.slave  bus,
   output logic                  empty_o,
   output logic                  wr_error_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BE_W  = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, DRAIN_REQ, DRAIN_WAIT, READ_REQ, READ_WAIT} state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, next_head;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [BE_W-1:0]       mem_be_q, mem_be_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  up_rvalid_q, up_rvalid_d, up_error_q, up_error_d;
   logic [DATA_WIDTH-1:0] up_rdata_q, up_rdata_d;
   logic                  wr_error_q, wr_error_d;
   logic                  push, pop, wr_gnt, rd_gnt;

   logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
   logic [BE_W-1:0]       fifo_be_q   [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];

   assign wr_gnt    = bus.up_req_i & bus.up_we_i & (count_q < CNT_W'(DEPTH));
   assign rd_gnt    = bus.up_req_i & ~bus.up_we_i & (count_q == '0) & (state_q == IDLE);
   assign push      = wr_gnt;
   assign next_head = head_q + PTR_W'(1);

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      up_rvalid_d = 1'b0;
      up_error_d  = up_error_q;
      up_rdata_d  = up_rdata_q;
      wr_error_d  = wr_error_q;
      pop         = 1'b0;

      if (push) begin
         tail_d      = tail_q + PTR_W'(1);
         up_rvalid_d = 1'b1;
         up_error_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d     = DRAIN_REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = fifo_addr_q[head_q];
               mem_be_d    = fifo_be_q[head_q];
               mem_wdata_d = fifo_data_q[head_q];
            end else if (rd_gnt) begin
               state_d     = READ_REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.up_addr_i;
               mem_be_d    = '1;
               mem_wdata_d = '0;
            end
         end
         DRAIN_REQ: begin
            if (bus.mem_gnt_i) begin
               state_d   = DRAIN_WAIT;
               mem_req_d = 1'b0;
            end
         end
         DRAIN_WAIT: begin
            if (bus.mem_rvalid_i) begin
               pop    = 1'b1;
               head_d = next_head;
               if (bus.mem_error_i) wr_error_d = 1'b1;
               if (count_q > CNT_W'(1)) begin
                  state_d     = DRAIN_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = fifo_addr_q[next_head];
                  mem_be_d    = fifo_be_q[next_head];
                  mem_wdata_d = fifo_data_q[next_head];
               end else if (push) begin
                  // The only remaining entry is the one being written this cycle: forward it.
                  state_d     = DRAIN_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = bus.up_addr_i;
                  mem_be_d    = bus.up_be_i;
                  mem_wdata_d = bus.up_wdata_i;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         READ_REQ: begin
            if (bus.mem_gnt_i) begin
               state_d   = READ_WAIT;
               mem_req_d = 1'b0;
            end
         end
         READ_WAIT: begin
            if (bus.mem_rvalid_i) begin
               state_d     = IDLE;
               up_rvalid_d = 1'b1;
               up_rdata_d  = bus.mem_rdata_i;
               up_error_d  = bus.mem_error_i;
            end
         end
         default: state_d = IDLE;
      endcase

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         up_rvalid_q <= 1'b0;
         up_error_q  <= 1'b0;
         up_rdata_q  <= '0;
         wr_error_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         up_rvalid_q <= up_rvalid_d;
         up_error_q  <= up_error_d;
         up_rdata_q  <= up_rdata_d;
         wr_error_q  <= wr_error_d;
      end
   end

   // Entry storage needs no reset: count/pointers decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[tail_q] <= bus.up_addr_i;
         fifo_be_q[tail_q]   <= bus.up_be_i;
         fifo_data_q[tail_q] <= bus.up_wdata_i;
      end
   end

   assign bus.up_gnt_o    = wr_gnt | rd_gnt;
   assign bus.up_rvalid_o = up_rvalid_q;
   assign bus.up_rdata_o  = up_rdata_q;
   assign bus.up_error_o  = up_error_q;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_be_o    = mem_be_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign empty_o         = (count_q == '0) && (state_q != DRAIN_REQ) && (state_q != DRAIN_WAIT);
   assign wr_error_o      = wr_error_q;
endmodule
